// File: rtl/dmi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dmi_cmd_sequencer
// Brief    : DMI master that queues host commands, retries busy answers,
//            times out lost responses and returns one response per command.
// Revision : 1.0 - initial release
// ============================================================================
module dmi_cmd_sequencer #(
  parameter int               ABITS     = 7,
  parameter int               CMD_DEPTH = 4,
  parameter int               RSP_DEPTH = 4,
  parameter int               MAX_RETRY = 8,
  parameter int               RETRY_GAP = 4,
  parameter int               TIMEOUT   = 1024,
  parameter logic [ABITS-1:0] EXIT_ADDR = {ABITS{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ABITS-1:0] cmd_addr,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_resp,
  output logic [31:0]      rsp_data,
  output logic             debug_req_valid,
  input  logic             debug_req_ready,
  output logic [ABITS-1:0] debug_req_bits_addr,
  output logic [1:0]       debug_req_bits_op,
  output logic [31:0]      debug_req_bits_data,
  input  logic             debug_resp_valid,
  output logic             debug_resp_ready,
  input  logic [1:0]       debug_resp_bits_resp,
  input  logic [31:0]      debug_resp_bits_data,
  output logic [31:0]      exit
);
  localparam int c_cmd_aw = $clog2(CMD_DEPTH);
  localparam int c_rsp_aw = $clog2(RSP_DEPTH);
  localparam int c_ret_w  = $clog2(MAX_RETRY + 2);
  localparam int c_tmr_w  = $clog2(TIMEOUT + 1);
  localparam int c_gap_w  = $clog2(RETRY_GAP + 1);
  localparam logic [c_cmd_aw:0]  c_cmd_full  = (c_cmd_aw + 1)'(CMD_DEPTH);
  localparam logic [c_rsp_aw:0]  c_rsp_full  = (c_rsp_aw + 1)'(RSP_DEPTH);
  localparam logic [c_ret_w-1:0] c_max_retry = c_ret_w'(MAX_RETRY);
  localparam logic [c_tmr_w-1:0] c_tmr_last  = c_tmr_w'(TIMEOUT - 1);
  localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'(RETRY_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_BACKOFF = 2'd3
  } state_t;

  state_t r_state;

  logic [ABITS-1:0]  r_cmd_addr [CMD_DEPTH];
  logic [1:0]        r_cmd_op   [CMD_DEPTH];
  logic [31:0]       r_cmd_data [CMD_DEPTH];
  logic [c_cmd_aw-1:0] r_cmd_wr, r_cmd_rd;
  logic [c_cmd_aw:0]   r_cmd_cnt;

  logic [1:0]        r_rsp_resp [RSP_DEPTH];
  logic [31:0]       r_rsp_data [RSP_DEPTH];
  logic [c_rsp_aw-1:0] r_rsp_wr, r_rsp_rd;
  logic [c_rsp_aw:0]   r_rsp_cnt;

  logic                r_from_fifo;
  logic [c_ret_w-1:0]  r_retry;
  logic [c_tmr_w-1:0]  r_timer;
  logic [c_gap_w-1:0]  r_gap;

  logic        w_cmd_empty, w_cmd_push, w_cmd_pop, w_head_exit, w_rsp_room;
  logic        w_rsp_push, w_rsp_pop, w_resp_accept, w_retry_ok;
  logic [1:0]  w_push_resp;
  logic [31:0] w_push_data;

  assign w_cmd_empty   = (r_cmd_cnt == '0);
  assign cmd_ready     = (r_cmd_cnt != c_cmd_full);
  assign w_cmd_push    = cmd_valid && cmd_ready;
  assign w_head_exit   = (r_cmd_op[r_cmd_rd] == 2'd2) && (r_cmd_addr[r_cmd_rd] == EXIT_ADDR);
  assign w_rsp_room    = (r_rsp_cnt != c_rsp_full);
  assign rsp_valid     = (r_rsp_cnt != '0);
  assign w_rsp_pop     = rsp_valid && rsp_ready;
  assign rsp_resp      = r_rsp_resp[r_rsp_rd];
  assign rsp_data      = r_rsp_data[r_rsp_rd];
  assign w_resp_accept = (r_state == ST_WAIT) && debug_resp_valid;
  assign w_retry_ok    = (debug_resp_bits_resp == 2'd3) && (r_retry < c_max_retry);

  // A command leaves the FIFO only on its first DMI handshake; retries reuse the held copy.
  assign w_cmd_pop = ((r_state == ST_IDLE) && !w_cmd_empty && w_rsp_room && w_head_exit) ||
                     ((r_state == ST_REQ) && debug_req_ready && r_from_fifo);

  always_comb begin
    w_rsp_push  = 1'b0;
    w_push_resp = 2'd0;
    w_push_data = 32'd0;
    if ((r_state == ST_IDLE) && !w_cmd_empty && w_rsp_room && w_head_exit) begin
      w_rsp_push = 1'b1;
    end else if (w_resp_accept) begin
      if (!w_retry_ok) begin
        w_rsp_push  = 1'b1;
        w_push_resp = debug_resp_bits_resp;
        w_push_data = debug_resp_bits_data;
      end
    end else if ((r_state == ST_WAIT) && (r_timer == c_tmr_last)) begin
      w_rsp_push  = 1'b1;
      w_push_resp = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cmd_push) begin
      r_cmd_addr[r_cmd_wr] <= cmd_addr;
      r_cmd_op[r_cmd_wr]   <= cmd_op;
      r_cmd_data[r_cmd_wr] <= cmd_data;
    end
    if (w_rsp_push) begin
      r_rsp_resp[r_rsp_wr] <= w_push_resp;
      r_rsp_data[r_rsp_wr] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_wr  <= '0;
      r_cmd_rd  <= '0;
      r_cmd_cnt <= '0;
      r_rsp_wr  <= '0;
      r_rsp_rd  <= '0;
      r_rsp_cnt <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wr <= r_cmd_wr + c_cmd_aw'(1);
      if (w_cmd_pop)  r_cmd_rd <= r_cmd_rd + c_cmd_aw'(1);
      if (w_cmd_push && !w_cmd_pop)      r_cmd_cnt <= r_cmd_cnt + (c_cmd_aw + 1)'(1);
      else if (!w_cmd_push && w_cmd_pop) r_cmd_cnt <= r_cmd_cnt - (c_cmd_aw + 1)'(1);
      if (w_rsp_push) r_rsp_wr <= r_rsp_wr + c_rsp_aw'(1);
      if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + c_rsp_aw'(1);
      if (w_rsp_push && !w_rsp_pop)      r_rsp_cnt <= r_rsp_cnt + (c_rsp_aw + 1)'(1);
      else if (!w_rsp_push && w_rsp_pop) r_rsp_cnt <= r_rsp_cnt - (c_rsp_aw + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      r_from_fifo         <= 1'b0;
      r_retry             <= '0;
      r_timer             <= '0;
      r_gap               <= '0;
      exit                <= 32'd0;
      debug_req_valid     <= 1'b0;
      debug_resp_ready    <= 1'b0;
      debug_req_bits_addr <= '0;
      debug_req_bits_op   <= 2'd0;
      debug_req_bits_data <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Only start when a response slot is free, so the result can always be stored.
          if (!w_cmd_empty && w_rsp_room) begin
            if (w_head_exit) begin
              exit <= r_cmd_data[r_cmd_rd] | 32'd1;
            end else begin
              debug_req_bits_addr <= r_cmd_addr[r_cmd_rd];
              debug_req_bits_op   <= r_cmd_op[r_cmd_rd];
              debug_req_bits_data <= r_cmd_data[r_cmd_rd];
              r_from_fifo         <= 1'b1;
              debug_req_valid     <= 1'b1;
              r_state             <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (debug_req_ready) begin
            debug_req_valid  <= 1'b0;
            r_from_fifo      <= 1'b0;
            debug_resp_ready <= 1'b1;
            r_timer          <= '0;
            r_state          <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (debug_resp_valid) begin
            debug_resp_ready <= 1'b0;
            if (w_retry_ok) begin
              r_retry <= r_retry + c_ret_w'(1);
              r_gap   <= '0;
              r_state <= ST_BACKOFF;
            end else begin
              r_retry <= '0;
              r_state <= ST_IDLE;
            end
          end else if (r_timer == c_tmr_last) begin
            debug_resp_ready <= 1'b0;
            r_retry          <= '0;
            r_state          <= ST_IDLE;
          end else begin
            r_timer <= r_timer + c_tmr_w'(1);
          end
        end
        default: begin
          if (r_gap == c_gap_last) begin
            debug_req_valid <= 1'b1;
            r_state         <= ST_REQ;
          end else begin
            r_gap <= r_gap + c_gap_w'(1);
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmi_cmd_sequencer
// Brief    : Scoreboard bench with a DMI responder driven from pre-drawn plans.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmi_cmd_sequencer;
  localparam int ABITS = 7, RSP_DEPTH = 2, MAX_RETRY = 2, RETRY_GAP = 4, TIMEOUT = 64;
  localparam logic [6:0] EXIT_ADDR = 7'h7f;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready;
  logic [6:0] cmd_addr = '0, debug_req_bits_addr;
  logic [1:0] cmd_op = '0, rsp_resp, debug_req_bits_op, debug_resp_bits_resp;
  logic [31:0] cmd_data = '0, rsp_data, debug_req_bits_data, debug_resp_bits_data, exit;
  logic debug_req_valid, debug_req_ready, debug_resp_valid, debug_resp_ready;

  always #5 clk = ~clk;

  dmi_cmd_sequencer #(.ABITS(ABITS), .CMD_DEPTH(4), .RSP_DEPTH(RSP_DEPTH), .MAX_RETRY(MAX_RETRY),
                      .RETRY_GAP(RETRY_GAP), .TIMEOUT(TIMEOUT), .EXIT_ADDR(EXIT_ADDR)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .debug_req_valid(debug_req_valid), .debug_req_ready(debug_req_ready),
    .debug_req_bits_addr(debug_req_bits_addr), .debug_req_bits_op(debug_req_bits_op),
    .debug_req_bits_data(debug_req_bits_data),
    .debug_resp_valid(debug_resp_valid), .debug_resp_ready(debug_resp_ready),
    .debug_resp_bits_resp(debug_resp_bits_resp), .debug_resp_bits_data(debug_resp_bits_data),
    .exit(exit)
  );

  // kind: 0..3 = DMI answers with that resp code, 4 = no answer at all
  typedef struct packed {
    logic [6:0] addr; logic [1:0] op; logic [31:0] wdata;
    int kind; int delay; logic [31:0] rdata; bit retry;
  } att_t;
  typedef struct packed { logic [1:0] resp; logic [31:0] data; } rsp_t;

  att_t plan_q[$];
  rsp_t exp_q[$];
  int   script_q[$];
  int   script_delay = -1;
  bit   use_fixed = 1'b0;
  logic [31:0] fixed_rdata = '0;
  logic [31:0] exp_exit = '0;
  int   n_checks = 0, n_fail = 0;
  int   req_count = 0, last_req_cyc = 0, cycle = 0;
  int   rsp_mode = 1;
  int   flush_req = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cycle);
    end
  endfunction

  function automatic int rand_kind();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 0;
    if (r < 63) return 1;
    if (r < 71) return 2;
    if (r < 95) return 3;
    return 4;
  endfunction

  // Reference model: expected outcome from the pre-drawn sequence of DMI answers.
  task automatic send_cmd(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
    rsp_t e;
    att_t t;
    int n, w;
    e.resp = 2'd0;
    e.data = 32'd0;
    if (op == 2'd2 && a == EXIT_ADDR) begin
      exp_exit = d | 32'd1;
    end else begin
      n = 0;
      forever begin
        t.addr  = a; t.op = op; t.wdata = d;
        t.kind  = (script_q.size() > 0) ? script_q.pop_front() : rand_kind();
        t.delay = (script_delay >= 0) ? script_delay : int'($urandom_range(0, 4));
        t.rdata = use_fixed ? fixed_rdata : $urandom;
        t.retry = (n > 0);
        plan_q.push_back(t);
        if (t.kind == 3 && n < MAX_RETRY) begin
          n++;
        end else begin
          e.resp = (t.kind == 4) ? 2'd2 : 2'(t.kind);
          e.data = (t.kind == 4) ? 32'd0 : t.rdata;
          break;
        end
      end
    end
    exp_q.push_back(e);
    cmd_addr = a; cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 2000) begin @(negedge clk); w++; end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 20000) begin @(negedge clk); w++; end
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    plan_q.delete();
    exp_q.delete();
    exp_exit = '0;
    flush_req++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // DMI responder: handshakes are predicted at the negedge before the edge that completes them.
  initial begin
    att_t cur;
    int sst, dly, stray, flush_seen, gap;
    sst = 0; dly = 0; stray = 0; flush_seen = 0; cur = '0;
    debug_req_ready = 1'b0; debug_resp_valid = 1'b0;
    debug_resp_bits_resp = 2'd0; debug_resp_bits_data = 32'd0;
    forever begin
      @(negedge clk);
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        sst = 2;
        stray = 4;
      end
      case (sst)
        0: begin
          debug_resp_valid = 1'b0;
          debug_req_ready  = ($urandom_range(0, 3) != 0);
          if (debug_req_valid && debug_req_ready && !reset) begin
            req_count++;
            if (plan_q.size() == 0) begin
              chk("dmi_unexpected_req", 32'(debug_req_valid), 32'd0);
            end else begin
              cur = plan_q.pop_front();
              chk("req_addr", 32'(debug_req_bits_addr), 32'(cur.addr));
              chk("req_op", 32'(debug_req_bits_op), 32'(cur.op));
              chk("req_data", debug_req_bits_data, cur.wdata);
              if (cur.retry) begin
                gap = cycle + 1 - last_req_cyc;
                chk("retry_gap_min", 32'(gap >= RETRY_GAP + 1), 32'd1);
              end
              last_req_cyc = cycle + 1;
              if (cur.kind != 4) begin dly = cur.delay; sst = 1; end
            end
          end
        end
        1: begin
          debug_req_ready = 1'b0;
          chk("single_outstanding", 32'(debug_req_valid), 32'd0);
          if (dly > 0) dly--;
          else begin
            debug_resp_valid     = 1'b1;
            debug_resp_bits_resp = 2'(cur.kind);
            debug_resp_bits_data = cur.rdata;
            if (debug_resp_ready) sst = 0;
          end
        end
        default: begin
          // Stale answer to a transaction that reset has already discarded.
          debug_req_ready      = 1'b0;
          debug_resp_bits_resp = 2'd0;
          debug_resp_bits_data = 32'h0bad_0bad;
          debug_resp_valid     = (stray > 0);
          if (stray > 0) stray--; else sst = 0;
        end
      endcase
    end
  end

  // Response monitor / scoreboard.
  initial begin
    rsp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rsp_mode)
        0: rsp_ready = 1'b0;
        1: rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (rsp_valid && rsp_ready && !reset) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          chk("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w, t0, seen;
    logic [6:0] a;
    logic [1:0] op;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_valid", 32'(debug_req_valid), 32'd0);
    chk("reset_resp_ready", 32'(debug_resp_ready), 32'd0);
    chk("reset_exit", exit, 32'd0);

    // Plain read
    rsp_mode = 1;
    r0 = req_count;
    script_q = '{0}; script_delay = 3; use_fixed = 1'b1; fixed_rdata = 32'hdeadbeef;
    send_cmd(7'h11, 2'd1, 32'd0);
    wait_drain("read_drain");
    chk("read_req_count", 32'(req_count - r0), 32'd1);
    use_fixed = 1'b0; script_delay = -1;

    // Busy twice then ok
    r0 = req_count;
    script_q = '{3, 3, 0};
    send_cmd(7'h10, 2'd2, 32'h1234_5678);
    wait_drain("retry_drain");
    chk("retry_req_count", 32'(req_count - r0), 32'd3);

    // Always busy: retries exhausted
    r0 = req_count;
    script_q = '{3, 3, 3};
    send_cmd(7'h22, 2'd1, 32'd0);
    wait_drain("busy_drain");
    chk("busy_req_count", 32'(req_count - r0), 32'd3);

    // Lost response -> timeout, then a normal command
    r0 = req_count;
    script_q = '{4};
    send_cmd(7'h05, 2'd1, 32'd0);
    w = 0;
    while (req_count == r0 && w < 500) begin @(negedge clk); w++; end
    t0 = last_req_cyc;
    w = 0;
    while (!rsp_valid && w < TIMEOUT + 100) begin @(negedge clk); w++; end
    chk("timeout_latency", 32'(cycle - t0), 32'(TIMEOUT));
    wait_drain("timeout_drain");
    script_q = '{0};
    send_cmd(7'h06, 2'd1, 32'd0);
    wait_drain("after_timeout_drain");
    chk("after_timeout_req_count", 32'(req_count - r0), 32'd2);

    // Response back-pressure: two in flight, command FIFO fills
    rsp_mode = 0; script_delay = 0;
    r0 = req_count;
    for (int i = 0; i < 6; i++) begin
      script_q.push_back(0);
      send_cmd(7'(8'h30 + i), 2'(1 + (i % 2)), 32'(i * 17));
    end
    repeat (20) @(negedge clk);
    chk("bp_req_count", 32'(req_count - r0), 32'd2);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_mode = 1;
    wait_drain("bp_drain");
    chk("bp_req_total", 32'(req_count - r0), 32'd6);
    script_delay = -1;

    // Exit interception
    r0 = req_count;
    send_cmd(EXIT_ADDR, 2'd2, 32'h4);
    wait_drain("exit_drain");
    chk("exit_value", exit, 32'h5);
    chk("exit_no_req", 32'(req_count - r0), 32'd0);
    send_cmd(EXIT_ADDR, 2'd2, 32'h30);
    wait_drain("exit2_drain");
    chk("exit_overwrite", exit, 32'h31);
    do_reset();
    @(negedge clk);
    chk("exit_after_reset", exit, 32'd0);
    repeat (8) @(negedge clk);

    // Reset mid-transaction; the late answer must be ignored
    r0 = req_count;
    script_q = '{0}; script_delay = 20;
    send_cmd(7'h44, 2'd1, 32'd0);
    w = 0;
    while (req_count == r0 && w < 500) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    do_reset();
    script_delay = -1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || debug_resp_ready || debug_req_valid) seen = 1;
    end
    chk("reset_drops_inflight", 32'(seen), 32'd0);
    script_q = '{0};
    send_cmd(7'h45, 2'd1, 32'd0);
    wait_drain("post_reset_drain");

    // Randomised traffic
    rsp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        send_cmd(EXIT_ADDR, 2'd2, $urandom);
      end else begin
        a  = 7'($urandom_range(0, 126));
        op = 2'($urandom_range(0, 3));
        send_cmd(a, op, $urandom);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("random_drain");
    chk("random_plan_consumed", 32'(plan_q.size()), 32'd0);
    chk("exit_final", exit, exp_exit);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
